// File: rtl/muldiv_pkg.sv
// Shared op codes, default latencies and op classification for the HI/LO mult/div unit.
// MULDIV_MADD_EN enables the madd/msub accumulate family.
package muldiv_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'd8;
  localparam logic [OP_W-1:0] MD_MADD  = 4'd9;
  localparam logic [OP_W-1:0] MD_MADDU = 4'd10;
  localparam logic [OP_W-1:0] MD_MSUB  = 4'd11;
  localparam logic [OP_W-1:0] MD_MSUBU = 4'd12;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  // Ops that occupy the unit for a multi-cycle latency and produce a pending result
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MULDIV_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational result generator: (op, a, b[, hi, lo]) -> pending HI/LO and write enable.
// With MULDIV_MADD_EN the current HI/LO feed the accumulate ops.
module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
`ifdef MULDIV_MADD_EN
  input  logic [31:0]     hiIn,
  input  logic [31:0]     loIn,
`endif
  output logic [31:0]     pendHi,
  output logic [31:0]     pendLo,
  output logic            pendWr
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic        signedDiv;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend
  always_comb begin
    prodS     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prodU     = {32'd0, a} * {32'd0, b};
    signedDiv = (op == MD_DIV);
    magA      = (signedDiv && a[31]) ? (~a + 32'd1) : a;
    magB      = (signedDiv && b[31]) ? (~b + 32'd1) : b;
    quo       = '0;
    rem       = '0;
    if (b != 32'd0) begin
      quo = magA / magB;
      rem = magA % magB;
    end
    if (signedDiv && (a[31] ^ b[31])) quo = ~quo + 32'd1;
    if (signedDiv && a[31])           rem = ~rem + 32'd1;
  end

  always_comb begin
    pendHi = '0;
    pendLo = '0;
    pendWr = 1'b0;
    case (op)
      MD_MULT: begin
        {pendHi, pendLo} = prodS;
        pendWr = 1'b1;
      end
      MD_MULTU: begin
        {pendHi, pendLo} = prodU;
        pendWr = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        pendHi = rem;
        pendLo = quo;
        pendWr = (b != 32'd0);
      end
`ifdef MULDIV_MADD_EN
      MD_MADD: begin
        {pendHi, pendLo} = {hiIn, loIn} + prodS;
        pendWr = 1'b1;
      end
      MD_MADDU: begin
        {pendHi, pendLo} = {hiIn, loIn} + prodU;
        pendWr = 1'b1;
      end
      MD_MSUB: begin
        {pendHi, pendLo} = {hiIn, loIn} - prodS;
        pendWr = 1'b1;
      end
      MD_MSUBU: begin
        {pendHi, pendLo} = {hiIn, loIn} - prodU;
        pendWr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner and mult/div sequencer: issue control, latency counter, D-stage stall request.
// MULDIV_MADD_EN adds the madd/maddu/msub/msubu accumulate ops.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op_e,
  input  logic [31:0]     a_e,
  input  logic [31:0]     b_e,
  input  logic            req,
  input  logic            d_md,
  output logic            start,
  output logic            busy,
  output logic            stall_req,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     rd_data
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [31:0]      hiNext;
  logic [31:0]      loNext;
  logic [31:0]      pendHi;
  logic [31:0]      pendLo;
  logic             pendWr;
  logic [31:0]      pendHiNext;
  logic [31:0]      pendLoNext;
  logic             pendWrNext;
  logic [31:0]      calcHi;
  logic [31:0]      calcLo;
  logic             calcWr;

  muldiv_calc uCalc (
    .op     (op_e),
    .a      (a_e),
    .b      (b_e),
`ifdef MULDIV_MADD_EN
    .hiIn   (hi),
    .loIn   (lo),
`endif
    .pendHi (calcHi),
    .pendLo (calcLo),
    .pendWr (calcWr)
  );

  assign busy      = (cnt != '0);
  assign start     = !reset && is_long_op(op_e) && !busy && !req;
  assign stall_req = d_md && (start || busy);
  assign rd_data   = (op_e == MD_MFHI) ? hi : ((op_e == MD_MFLO) ? lo : 32'd0);

  // Next-state: issue loads counter and pending result; completion commits on the 1->0 step
  always_comb begin
    cntNext    = cnt;
    hiNext     = hi;
    loNext     = lo;
    pendHiNext = pendHi;
    pendLoNext = pendLo;
    pendWrNext = pendWr;
    if (start) begin
      cntNext    = is_div_op(op_e) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      pendHiNext = calcHi;
      pendLoNext = calcLo;
      pendWrNext = calcWr;
    end else if (busy) begin
      cntNext = cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && pendWr) begin
        hiNext = pendHi;
        loNext = pendLo;
      end
    end else if (!req) begin
      if (op_e == MD_MTHI) hiNext = a_e;
      if (op_e == MD_MTLO) loNext = a_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      pendHi <= '0;
      pendLo <= '0;
      pendWr <= 1'b0;
    end else begin
      cnt    <= cntNext;
      hi     <= hiNext;
      lo     <= loNext;
      pendHi <= pendHiNext;
      pendLo <= pendLoNext;
      pendWr <= pendWrNext;
    end
  end

endmodule
